// File: rtl/writeback_unit_pkg.sv
// Shared integer register-file constants and the writeback entry layout {rd, data}
// used by writeback_unit and wb_fifo.
package writeback_unit_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   typedef struct packed {
      reg_addr_t       rd;
      logic [XLEN-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result buffer: up to two pushes (push0 lands ahead of push1) and one pop per cycle.
// The caller guarantees free space for every push it asserts.
module wb_fifo
   import writeback_unit_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push0_i,
   input  wb_entry_t        push0_data_i,
   input  logic             push1_i,
   input  wb_entry_t        push1_data_i,
   input  logic             pop_i,
   output wb_entry_t        head_o,
   output logic [CNT_W-1:0] count_o
);

   wb_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_ptr1;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign wr_ptr1 = wr_ptr_q + PTR_W'(push0_i);

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr1 + PTR_W'(push1_i);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(do_pop);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; pointers and count alone define validity.
   always_ff @(posedge clock) begin
      if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
      if (push1_i) mem_q[wr_ptr1]  <= push1_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback front end: mem/ALU result arbitration, FIFO drain to the write port,
// and the pending-write scoreboard. Define WB_BYPASS_EN to let a beat skip an empty FIFO.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            mem_valid,
   input  reg_addr_t       mem_rd,
   input  logic [XLEN-1:0] mem_data,
   output logic            mem_ready,
   input  logic            alu_valid,
   input  reg_addr_t       alu_rd,
   input  logic [XLEN-1:0] alu_data,
   output logic            alu_ready,
   input  logic            issue_valid,
   input  reg_addr_t       issue_rd,
   input  reg_addr_t       check_reg_0,
   input  reg_addr_t       check_reg_1,
   output logic            pending_0,
   output logic            pending_1,
   output reg_addr_t       write_reg,
   output logic [XLEN-1:0] write_data,
   output logic            write_enable,
   output logic            empty
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [CNT_W-1:0]    count, free;
   logic                fifo_empty, mem_keep, alu_keep, byp_mem, byp_alu, push0, push1;
   wb_entry_t           head;
   logic                we_q, we_d;
   reg_addr_t           wreg_q, wreg_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [NUM_REGS-1:0] sb_q, sb_d;

   // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
   assign free       = CNT_W'(FIFO_DEPTH) - count;
   assign fifo_empty = (count == '0);
   assign mem_ready  = !reset && (free != '0);
   assign alu_ready  = !reset && (mem_valid ? (free >= CNT_W'(2)) : (free != '0));

   // Accepted beats to x0 are dropped here: they never reach the FIFO or the scoreboard.
   assign mem_keep = mem_valid && mem_ready && (mem_rd != '0);
   assign alu_keep = alu_valid && alu_ready && (alu_rd != '0);

`ifdef WB_BYPASS_EN
   assign byp_mem = fifo_empty && mem_keep;
   assign byp_alu = fifo_empty && !mem_keep && alu_keep;
`else
   assign byp_mem = 1'b0;
   assign byp_alu = 1'b0;
`endif

   assign push0 = mem_keep && !byp_mem;
   assign push1 = alu_keep && !byp_alu;

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock        (clock),
      .reset        (reset),
      .push0_i      (push0),
      .push0_data_i ('{rd: mem_rd, data: mem_data}),
      .push1_i      (push1),
      .push1_data_i ('{rd: alu_rd, data: alu_data}),
      .pop_i        (!fifo_empty),
      .head_o       (head),
      .count_o      (count)
   );

   always_comb begin
      we_d    = 1'b0;
      wreg_d  = wreg_q;
      wdata_d = wdata_q;
      if (!fifo_empty) begin
         we_d    = 1'b1;
         wreg_d  = head.rd;
         wdata_d = head.data;
      end else if (byp_mem) begin
         we_d    = 1'b1;
         wreg_d  = mem_rd;
         wdata_d = mem_data;
      end else if (byp_alu) begin
         we_d    = 1'b1;
         wreg_d  = alu_rd;
         wdata_d = alu_data;
      end
   end

   // The clear is applied first so a same-edge issue to the committing register wins.
   always_comb begin
      sb_d = sb_q;
      if (we_q) sb_d[wreg_q] = 1'b0;
      if (issue_valid && (issue_rd != '0)) sb_d[issue_rd] = 1'b1;
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         we_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
         sb_q    <= '0;
      end else begin
         we_q    <= we_d;
         wreg_q  <= wreg_d;
         wdata_q <= wdata_d;
         sb_q    <= sb_d;
      end
   end

   assign pending_0    = (check_reg_0 != '0) && sb_q[check_reg_0];
   assign pending_1    = (check_reg_1 != '0) && sb_q[check_reg_1];
   assign write_enable = we_q;
   assign write_reg    = wreg_q;
   assign write_data   = wdata_q;
   assign empty        = fifo_empty && !we_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: latency, dual accept, backpressure/order, x0 discard,
// scoreboard set/clear, and mid-operation reset.
module tb_writeback_unit;
   import writeback_unit_pkg::*;

`ifdef WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic            clock = 1'b0;
   logic            reset;
   logic            mem_valid, alu_valid, issue_valid;
   reg_addr_t       mem_rd, alu_rd, issue_rd, check_reg_0, check_reg_1;
   logic [XLEN-1:0] mem_data, alu_data;
   logic            mem_ready, alu_ready, pending_0, pending_1, write_enable, empty;
   reg_addr_t       write_reg;
   logic [XLEN-1:0] write_data;

   int errors = 0;
   int checks = 0;
   logic [REG_ADDR_W+XLEN-1:0] wq[$];

   always #5 clock = ~clock;

   writeback_unit #(.FIFO_DEPTH(4)) dut (
      .clock        (clock),
      .reset        (reset),
      .mem_valid    (mem_valid),
      .mem_rd       (mem_rd),
      .mem_data     (mem_data),
      .mem_ready    (mem_ready),
      .alu_valid    (alu_valid),
      .alu_rd       (alu_rd),
      .alu_data     (alu_data),
      .alu_ready    (alu_ready),
      .issue_valid  (issue_valid),
      .issue_rd     (issue_rd),
      .check_reg_0  (check_reg_0),
      .check_reg_1  (check_reg_1),
      .pending_0    (pending_0),
      .pending_1    (pending_1),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .write_enable (write_enable),
      .empty        (empty)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, settle, and log any register-file write visible in the new cycle.
   task automatic tick();
      @(posedge clock);
      #1;
      if (write_enable === 1'b1) wq.push_back({write_reg, write_data});
   endtask

   task automatic wait_we(input string tag);
      int n = 0;
      while (write_enable !== 1'b1 && n < 6) begin
         tick();
         n++;
      end
      chk(tag, 64'(write_enable), 64'd1);
   endtask

   task automatic issue(input reg_addr_t rd);
      check_reg_1 = rd;
      #1;
      chk("issue_legal", 64'(pending_1 === 1'b0 || (write_enable === 1'b1 && write_reg === rd)), 64'd1);
      issue_valid = 1'b1;
      issue_rd    = rd;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int next_alu;
      bit exp_ar[4];
      int exp_rd[$];

      reset = 1'b1;
      mem_valid = 1'b0; alu_valid = 1'b0; issue_valid = 1'b0;
      mem_rd = '0; alu_rd = '0; issue_rd = '0; check_reg_0 = '0; check_reg_1 = '0;
      mem_data = '0; alu_data = '0;
      #1;
      chk("rst_we", 64'(write_enable), 64'd0);
      chk("rst_wreg", 64'(write_reg), 64'd0);
      chk("rst_wdata", 64'(write_data), 64'd0);
      chk("rst_empty", 64'(empty), 64'd1);
      mem_valid = 1'b1; alu_valid = 1'b1;
      #1;
      chk("rst_mem_ready", 64'(mem_ready), 64'd0);
      chk("rst_alu_ready", 64'(alu_ready), 64'd0);
      mem_valid = 1'b0; alu_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      chk("rel_mem_ready", 64'(mem_ready), 64'd1);

      // Single ALU beat latency.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      chk("t1_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         chk("t1_early_we", 64'(write_enable), 64'd0);
         tick();
      end
      chk("t1_we", 64'(write_enable), 64'd1);
      chk("t1_wreg", 64'(write_reg), 64'd5);
      chk("t1_wdata", 64'(write_data), 64'hDEADBEEF);
      tick();
      chk("t1_we_off", 64'(write_enable), 64'd0);
      chk("t1_empty", 64'(empty), 64'd1);

      // Dual accept into an empty FIFO: mem first.
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h22;
      #1;
      chk("t2_mem_ready", 64'(mem_ready), 64'd1);
      chk("t2_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0;
      for (int i = 1; i < LAT; i++) tick();
      chk("t2_w0", 64'({write_enable, write_reg, write_data}), 64'({1'b1, 5'd3, 32'h11}));
      tick();
      chk("t2_w1", 64'({write_enable, write_reg, write_data}), 64'({1'b1, 5'd4, 32'h22}));
      tick();
      chk("t2_we_off", 64'(write_enable), 64'd0);

      // Both sources held valid: ALU backpressure, order preserved.
`ifdef WB_BYPASS_EN
      exp_ar = '{1'b1, 1'b1, 1'b1, 1'b0};
      exp_rd = '{8, 9, 10, 11, 12, 13, 14};
`else
      exp_ar = '{1'b1, 1'b1, 1'b0, 1'b0};
      exp_rd = '{8, 9, 10, 11, 12, 14};
`endif
      wq.delete();
      next_alu = 9;
      for (int i = 0; i < 4; i++) begin
         mem_valid = 1'b1; mem_rd = 5'(8 + 2 * i); mem_data = 32'(32'h100 + 8 + 2 * i);
         alu_valid = 1'b1; alu_rd = 5'(next_alu);  alu_data = 32'(32'h100 + next_alu);
         #1;
         chk("t3_mem_ready", 64'(mem_ready), 64'd1);
         chk("t3_alu_ready", 64'(alu_ready), 64'(exp_ar[i]));
         if (exp_ar[i]) next_alu += 2;
         tick();
      end
      mem_valid = 1'b0; alu_valid = 1'b0;
      repeat (10) tick();
      chk("t3_count", 64'(wq.size()), 64'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size(); i++)
         chk("t3_order", (i < wq.size()) ? 64'(wq[i]) : 64'hBAD,
             64'({5'(exp_rd[i]), 32'(32'h100 + exp_rd[i])}));
      chk("t3_empty", 64'(empty), 64'd1);

      // Beat to x0 is accepted and discarded.
      wq.delete();
      check_reg_0 = 5'd0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
      #1;
      chk("t4_alu_ready", 64'(alu_ready), 64'd1);
      tick();
      alu_valid = 1'b0;
      repeat (4) tick();
      chk("t4_no_write", 64'(wq.size()), 64'd0);
      chk("t4_pending0", 64'(pending_0), 64'd0);
      chk("t4_empty", 64'(empty), 64'd1);

      // Scoreboard set, hold, same-edge re-issue, final clear.
      check_reg_0 = 5'd7;
      issue(5'd7);
      tick();
      issue_valid = 1'b0;
      chk("t5_set", 64'(pending_0), 64'd1);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      tick();
      alu_valid = 1'b0;
      chk("t5_hold", 64'(pending_0), 64'd1);
      wait_we("t5_c1_we");
      chk("t5_c1_wreg", 64'(write_reg), 64'd7);
      chk("t5_c1_pending", 64'(pending_0), 64'd1);
      issue(5'd7);
      tick();
      issue_valid = 1'b0;
      chk("t5_reissue", 64'(pending_0), 64'd1);
      chk("t5_reissue_we", 64'(write_enable), 64'd0);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h78;
      tick();
      alu_valid = 1'b0;
      wait_we("t5_c2_we");
      chk("t5_c2_wdata", 64'(write_data), 64'h78);
      tick();
      chk("t5_clear", 64'(pending_0), 64'd0);

      // Reset with entries buffered.
      mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB0;
      tick();
      mem_rd = 5'd12; mem_data = 32'hC0;
      alu_rd = 5'd13; alu_data = 32'hD0;
      tick();
      mem_valid = 1'b0; alu_valid = 1'b0;
      #1;
      chk("t6_pre_we", 64'(write_enable), 64'd1);
      chk("t6_pre_empty", 64'(empty), 64'd0);
      #1 reset = 1'b1;
      #1;
      chk("t6_rst_we", 64'(write_enable), 64'd0);
      chk("t6_rst_wreg", 64'(write_reg), 64'd0);
      chk("t6_rst_empty", 64'(empty), 64'd1);
      chk("t6_rst_ready", 64'({mem_ready, alu_ready}), 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      wq.delete();
      repeat (6) tick();
      chk("t6_no_write", 64'(wq.size()), 64'd0);
      chk("t6_empty", 64'(empty), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Writer-side front end for the integer register file. Accepts result beats from the ALU path and the load/memory path through valid/ready handshakes and buffers them in a small in-order FIFO. Drains one entry per cycle onto the register file write port (write_reg/write_data/write_enable). Keeps a pending-write scoreboard that decode queries for RAW/WAW stalls.

Parameters:
XLEN, 32, data width; taken from the riscv.h constants.
FIFO_DEPTH, 4, result buffer entries; power of two, >= 2.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
mem_valid  in  1  load result beat valid
mem_rd  in  5  load destination register
mem_data  in  XLEN  load result
mem_ready  out  1  load beat accepted when valid&ready
alu_valid  in  1  ALU result beat valid
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU beat accepted when valid&ready
issue_valid  in  1  decode issued an instruction that writes issue_rd
issue_rd  in  5  destination of the issued instruction
check_reg_0  in  5  decode source query 0
check_reg_1  in  5  decode source query 1
pending_0  out  1  write to check_reg_0 outstanding
pending_1  out  1  write to check_reg_1 outstanding
write_reg  out  5  to register file write_reg
write_data  out  XLEN  to register file write_data
write_enable  out  1  to register file write_enable
empty  out  1  FIFO and output stage idle

Behaviour:
- Reset (async, active-high): FIFO pointers/count = 0, scoreboard = all 0, write_enable = 0, write_reg = 0, write_data = 0. empty = 1. mem_ready = alu_ready = 0 while reset is high.
- free = FIFO_DEPTH - count, using the registered count only. A same-cycle pop does not raise ready.
- mem_ready = (free >= 1). alu_ready = (free >= 2) if mem_valid, else (free >= 1).
- Both beats may be accepted in one cycle. Enqueue order is mem first, then alu. FIFO order is write order.
- A beat with rd == 0 is accepted normally (consumes no slot, counted out of free) and is discarded: no write, no scoreboard effect.
- Drain: on each edge, if the FIFO is non-empty, pop the head into registered write_reg/write_data with write_enable <= 1. Otherwise write_enable <= 0.
- Latency: beat accepted at edge N into an empty FIFO gives write_enable high in the cycle after edge N+1. The register file captures it at edge N+2.
- count is updated by pushes minus pop, width clog2(FIFO_DEPTH+1). Pointers wrap modulo FIFO_DEPTH.
- Scoreboard: one bit per register; bit 0 is hard-wired 0.
  - Set at an edge with issue_valid and issue_rd != 0.
  - Cleared at an edge where write_enable == 1 for that register, i.e. the same edge the register file commits.
  - Set and clear of the same register on the same edge: the bit ends set.
- pending_x = scoreboard[check_reg_x], combinational; 0 when check_reg_x == 0.
- Decode must not issue to a register that is already pending (WAW stall is decode's responsibility). The bench asserts this.
- empty = (count == 0) && !write_enable.
- Reset mid-operation: buffered entries are lost and write_enable drops immediately. No writes occur after reset release until new beats arrive.

Optional Feature:
WB_BYPASS_EN. When defined and the FIFO is empty at an edge, the first accepted beat (mem priority) loads the output registers directly. Any second beat is enqueued. Latency drops to write_enable high in the cycle after the accept edge.
When undefined, every beat passes through the FIFO (latency 2, as above).

Decomposition:
- Shared constants in riscv.h: XLEN, REG_ADDR_W = 5, NUM_REGS = 32, plus a wb_entry layout of {rd[4:0], data[XLEN-1:0]}.
- One natural sub-module: wb_fifo, a synchronous dual-push/single-pop FIFO with count output.
- Scoreboard, arbitration and output stage stay in writeback_unit.

Test Plan:
- Reset, then alu_valid rd=5 data=0xDEADBEEF -> alu_ready=1; write_enable=1, write_reg=5, write_data=0xDEADBEEF exactly 2 cycles later (1 with WB_BYPASS_EN).
- Same cycle: mem rd=3 0x11 and alu rd=4 0x22 with FIFO empty -> both accepted; writes appear rd3 then rd4 on consecutive cycles.
- DEPTH=4, both valid held every cycle -> count climbs by 1/cycle; alu_ready drops when free < 2; mem_ready drops at free == 0; no lost or reordered beats.
- alu rd=0 data=0xFFFFFFFF -> accepted; write_enable never asserts for it; pending_0 (check_reg_0=0) stays 0.
- issue rd=7, then alu rd=7 -> pending_0 (check_reg_0=7) high from the edge after issue until the edge where write_enable with write_reg=7 commits; same-edge re-issue of 7 keeps it high.
- Three entries buffered, assert reset mid-cycle -> write_enable falls asynchronously; empty=1 and no writes after release.
